// File: rtl/vz_pkg.sv
// Shared constants, state encoding and header-byte helpers for the VZ snapshot uploader.
package vz_pkg;

  localparam int          VZ_HDR_LEN    = 24;
  localparam logic [31:0] VZ_MAGIC      = 32'h565A_4630;   // "VZF0"
  localparam logic [127:0] VZ_NAME      = "LASER310 UPLOAD ";
  localparam logic [7:0]  VZ_TYPE_BASIC = 8'hF0;
  localparam logic [7:0]  VZ_TYPE_BIN   = 8'hF1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_HDR   = 3'd2,
    ST_MREQ  = 3'd3,
    ST_MWAIT = 3'd4,
    ST_PAD   = 3'd5
  } vz_state_e;

  // Magic and name are stored first-character-in-MSB, as string literals pack.
  function automatic logic [7:0] vz_magic_byte(input logic [1:0] idx);
    return VZ_MAGIC[{2'd3 - idx, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] vz_name_byte(input logic [3:0] idx);
    return VZ_NAME[{4'd15 - idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/vz_upload_if.sv
// Bus bundle between hps_io (upload channel) and the RAM arbiter port.
interface vz_upload_if;
  // ioctl side: ioctl_rd is a one-cycle strobe qualified by ioctl_addr; the byte is
  // valid on ioctl_din in the first cycle ioctl_wait is low after the strobe.
  // mem side: mem_rd is a request held high until the one-cycle mem_ack, which
  // qualifies mem_din; a request is never withdrawn before ack or timeout.
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [7:0]  mem_din;

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, mem_ack, mem_din,
    output ioctl_din, ioctl_wait, mem_addr, mem_rd
  );

  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, mem_ack, mem_din,
    input  ioctl_din, ioctl_wait, mem_addr, mem_rd
  );
endinterface

// File: rtl/vz_hdr_rom.sv
// Combinational offset-to-byte mux for the 24-byte VZ header.
module vz_hdr_rom
  import vz_pkg::*;
(
  input  logic [4:0]  idx_i,
  input  logic [7:0]  file_type_i,
  input  logic [15:0] start_addr_i,
  output logic [7:0]  byte_o
);

  always_comb begin
    byte_o = 8'h00;
    if (idx_i < 5'd4) begin
      byte_o = vz_magic_byte(idx_i[1:0]);
    end else if (idx_i < 5'd20) begin
      byte_o = vz_name_byte(4'(idx_i - 5'd4));
    end else begin
      // byte 20 terminates the name; offsets past 23 never reach this mux
      case (idx_i)
        5'd21:   byte_o = file_type_i;
        5'd22:   byte_o = start_addr_i[7:0];
        5'd23:   byte_o = start_addr_i[15:8];
        default: byte_o = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/vz_upload.sv
// VZ snapshot uploader: header synthesis plus RAM streaming onto the hps_io upload channel.
// Optional macro VZ_UPLOAD_SUM_EN adds the upload_sum payload checksum output.
module vz_upload
  import vz_pkg::*;
#(
  parameter int HDR_LEN     = VZ_HDR_LEN,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              reset,
  vz_upload_if.slave        bus,
  input  logic [15:0]       start_addr,
  input  logic [15:0]       end_addr,
  input  logic [7:0]        file_type,
  output logic [15:0]       upload_size,
  output logic              busy,
`ifdef VZ_UPLOAD_SUM_EN
  output logic [15:0]       upload_sum,
`endif
  output vz_state_e         state_o
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

  vz_state_e        state_q;
  logic             upload_q;
  logic             busy_q;
  logic             abort_q;
  logic [15:0]      start_q;
  logic [7:0]       type_q;
  logic [15:0]      size_q;
  logic [7:0]       din_q;
  logic             wait_q;
  logic [15:0]      mem_addr_q;
  logic             mem_rd_q;
  logic [TMO_W-1:0] tmo_q;
`ifdef VZ_UPLOAD_SUM_EN
  logic [15:0]      sum_q;
`endif

  logic        up_rise;
  logic [15:0] payload_d;
  logic [16:0] size_wide;
  logic [15:0] size_d;
  logic [15:0] mem_addr_d;
  logic        is_hdr;
  logic        is_mem;
  logic        mem_done;
  logic [7:0]  mem_byte;
  logic [7:0]  hdr_byte;

  assign up_rise    = bus.ioctl_upload & ~upload_q;
  assign payload_d  = (end_addr > start_addr) ? (end_addr - start_addr) : 16'h0000;
  assign size_wide  = {1'b0, payload_d} + 17'(HDR_LEN);
  assign size_d     = size_wide[16] ? 16'hFFFF : size_wide[15:0];
  assign mem_addr_d = start_q + (bus.ioctl_addr - 16'(HDR_LEN));
  assign is_hdr     = bus.ioctl_addr < 16'(HDR_LEN);
  assign is_mem     = bus.ioctl_addr < size_q;
  assign mem_done   = bus.mem_ack || (tmo_q == TMO_W'(MEM_TIMEOUT - 1));
  assign mem_byte   = bus.mem_ack ? bus.mem_din : 8'hFF;

  vz_hdr_rom u_hdr_rom (
    .idx_i        (bus.ioctl_addr[4:0]),
    .file_type_i  (type_q),
    .start_addr_i (start_q),
    .byte_o       (hdr_byte)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      upload_q   <= 1'b0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
      start_q    <= 16'h0000;
      type_q     <= 8'h00;
      size_q     <= 16'h0000;
      din_q      <= 8'h00;
      wait_q     <= 1'b0;
      mem_addr_q <= 16'h0000;
      mem_rd_q   <= 1'b0;
      tmo_q      <= '0;
`ifdef VZ_UPLOAD_SUM_EN
      sum_q      <= 16'h0000;
`endif
    end else begin
      upload_q <= bus.ioctl_upload;
      case (state_q)
        ST_MREQ, ST_MWAIT: begin
          // The request stays up even if the session ends, so the arbiter is never left hanging.
          if (!bus.ioctl_upload) abort_q <= 1'b1;
          if (mem_done) begin
            mem_rd_q <= 1'b0;
            wait_q   <= 1'b0;
            tmo_q    <= '0;
            if (abort_q || !bus.ioctl_upload) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              abort_q <= 1'b0;
            end else begin
              din_q   <= mem_byte;
              state_q <= ST_READY;
`ifdef VZ_UPLOAD_SUM_EN
              sum_q   <= sum_q + {8'h00, mem_byte};
`endif
            end
          end else begin
            tmo_q   <= tmo_q + 1'b1;
            state_q <= ST_MWAIT;
          end
        end
        default: begin
          if (up_rise) begin
            // A read strobe coincident with the session edge is dropped.
            start_q <= start_addr;
            type_q  <= file_type;
            size_q  <= size_d;
            busy_q  <= 1'b1;
            abort_q <= 1'b0;
            state_q <= ST_READY;
`ifdef VZ_UPLOAD_SUM_EN
            sum_q   <= 16'h0000;
`endif
          end else if (state_q == ST_IDLE) begin
            state_q <= ST_IDLE;
          end else if (!bus.ioctl_upload) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (bus.ioctl_rd) begin
            if (is_hdr) begin
              din_q   <= hdr_byte;
              state_q <= ST_HDR;
            end else if (is_mem) begin
              mem_addr_q <= mem_addr_d;
              mem_rd_q   <= 1'b1;
              wait_q     <= 1'b1;
              tmo_q      <= '0;
              state_q    <= ST_MREQ;
            end else begin
              din_q   <= 8'h00;
              state_q <= ST_PAD;
            end
          end else begin
            state_q <= ST_READY;
          end
        end
      endcase
    end
  end

  assign bus.ioctl_din  = din_q;
  assign bus.ioctl_wait = wait_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_rd     = mem_rd_q;
  assign upload_size    = size_q;
  assign busy           = busy_q;
  assign state_o        = state_q;
`ifdef VZ_UPLOAD_SUM_EN
  assign upload_sum     = sum_q;
`endif

endmodule

// File: tb/tb_vz_upload.sv
// Self-checking bench for vz_upload: header, payload, padding, timeout, abort and reset.
module tb_vz_upload;
  import vz_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] start_addr;
  logic [15:0] end_addr;
  logic [7:0]  file_type;
  logic [15:0] upload_size;
  logic        busy;
  vz_state_e   dbg_state;
`ifdef VZ_UPLOAD_SUM_EN
  logic [15:0] upload_sum;
`endif

  vz_upload_if bus ();

  vz_upload dut (
    .clk_sys     (clk),
    .reset       (reset),
    .bus         (bus),
    .start_addr  (start_addr),
    .end_addr    (end_addr),
    .file_type   (file_type),
    .upload_size (upload_size),
    .busy        (busy),
`ifdef VZ_UPLOAD_SUM_EN
    .upload_sum  (upload_sum),
`endif
    .state_o     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0]  exp_q[$];
  logic [7:0]  ram [0:65535];
  logic [7:0]  hdr [0:23];
  logic [15:0] s_start;
  logic [15:0] s_size;
  logic [7:0]  last_exp;
  int          n_checks;
  int          n_errors;
  int          mem_rd_cycles;
  bit          ack_en;
  int          ack_delay;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) if (bus.mem_rd === 1'b1) mem_rd_cycles++;

  // RAM arbiter model: acknowledges a held request after ack_delay further cycles.
  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_din = 8'h00;
    forever begin
      @(posedge clk); #2;
      if (bus.mem_rd === 1'b1 && ack_en) begin
        repeat (ack_delay) @(posedge clk);
        #2;
        bus.mem_ack = 1'b1;
        bus.mem_din = ram[bus.mem_addr];
        @(posedge clk); #2;
        bus.mem_ack = 1'b0;
        bus.mem_din = 8'h00;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_byte(input logic [15:0] off);
    logic [15:0] a;
    if (off < 16'd24) return hdr[off[4:0]];
    if (off < s_size) begin
      if (!ack_en) return 8'hFF;
      a = s_start + off - 16'd24;
      return ram[a];
    end
    return 8'h00;
  endfunction

  task automatic build_model(input logic [15:0] s, input logic [15:0] e, input logic [7:0] t);
    string magic;
    string nm;
    int    sz;
    magic = "VZF0";
    nm    = "LASER310 UPLOAD ";
    for (int i = 0; i < 4; i++)  hdr[i] = magic.getc(i);
    for (int i = 0; i < 16; i++) hdr[4 + i] = nm.getc(i);
    hdr[20] = 8'h00;
    hdr[21] = t;
    hdr[22] = s[7:0];
    hdr[23] = s[15:8];
    sz = (e > s) ? (int'(e) - int'(s) + 24) : 24;
    s_size  = (sz > 65535) ? 16'hFFFF : 16'(sz);
    s_start = s;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_session(input logic [15:0] s, input logic [15:0] e, input logic [7:0] t,
                               input bit with_rd);
    build_model(s, e, t);
    @(negedge clk);
    start_addr       = s;
    end_addr         = e;
    file_type        = t;
    bus.ioctl_upload = 1'b1;
    if (with_rd) begin
      bus.ioctl_rd   = 1'b1;
      bus.ioctl_addr = 16'd0;
    end
    @(posedge clk); #1;
    bus.ioctl_rd = 1'b0;
    check("size", upload_size, s_size);
    check("busy_start", busy, 1'b1);
    if (with_rd) begin
      check("edge_rd_state", dbg_state, ST_READY);
      check("edge_rd_din", bus.ioctl_din, 8'h00);
    end
  endtask

  task automatic end_session();
    @(negedge clk);
    bus.ioctl_upload = 1'b0;
    @(posedge clk); #1;
    check("busy_end", busy, 1'b0);
    check("state_end", dbg_state, ST_IDLE);
    check("size_held", upload_size, s_size);
  endtask

  task automatic do_read(input logic [15:0] off, input int exp_wait);
    int          waited;
    logic [7:0]  exp;
    logic [15:0] exp_addr;
    bit          is_mem;
    is_mem   = (off >= 16'd24) && (off < s_size);
    exp_addr = s_start + off - 16'd24;
    exp_q.push_back(model_byte(off));
    @(negedge clk);
    bus.ioctl_addr = off;
    bus.ioctl_rd   = 1'b1;
    @(posedge clk); #1;
    bus.ioctl_rd = 1'b0;
    if (is_mem) begin
      check("mem_addr", bus.mem_addr, exp_addr);
      check("mem_rd_hi", bus.mem_rd, 1'b1);
    end else begin
      check("mem_rd_lo", bus.mem_rd, 1'b0);
    end
    waited = 0;
    while (bus.ioctl_wait === 1'b1 && waited < 400) begin
      @(posedge clk); #1;
      waited++;
    end
    check("rd_lat", waited, exp_wait);
    check("mem_rd_done", bus.mem_rd, 1'b0);
    exp      = exp_q.pop_front();
    last_exp = exp;
    check("rd_data", bus.ioctl_din, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int snap;
    n_checks = 0;
    n_errors = 0;
    mem_rd_cycles = 0;
    ack_en    = 1'b1;
    ack_delay = 3;
    s_start   = 16'h0;
    s_size    = 16'h0;
    last_exp  = 8'h00;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    reset            = 1'b1;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = 16'h0;
    start_addr       = 16'h0;
    end_addr         = 16'h0;
    file_type        = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_din", bus.ioctl_din, 8'h00);
    check("rst_wait", bus.ioctl_wait, 1'b0);
    check("rst_mem_rd", bus.mem_rd, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 16'h0);
    check("rst_size", upload_size, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    reset = 1'b0;

    // Header, with a read strobe coincident with the session edge
    ram[16'h7AE9] = 8'h5A;
    start_session(16'h7AE9, 16'h7B00, VZ_TYPE_BASIC, 1'b1);
    check("size_47", upload_size, 16'd47);
    for (int i = 0; i < 24; i++) do_read(16'(i), 0);

    // Payload: first byte with ack after 3 cycles, last byte, then first pad offset
    ack_delay = 3;
    do_read(16'd24, 4);
    ack_delay = 1;
    do_read(16'd46, 2);
    do_read(16'd47, 0);
    end_session();

    // Empty program, and end before start: header only, pads never touch RAM
    start_session(16'h8000, 16'h8000, VZ_TYPE_BIN, 1'b0);
    check("size_empty", upload_size, 16'd24);
    snap = mem_rd_cycles;
    do_read(16'd24, 0);
    do_read(16'd100, 0);
    do_read(16'd21, 0);
    check("pad_no_mem", mem_rd_cycles, snap);
    end_session();
    start_session(16'h9000, 16'h8000, VZ_TYPE_BIN, 1'b0);
    check("size_neg", upload_size, 16'd24);
    end_session();
    start_session(16'h0000, 16'hFFFF, VZ_TYPE_BIN, 1'b0);
    check("size_sat", upload_size, 16'hFFFF);
    do_read(16'hFFFE, 2);
    end_session();

    // Timeout: no acknowledge at all
    ack_en = 1'b0;
    start_session(16'h1000, 16'h1010, VZ_TYPE_BIN, 1'b0);
    do_read(16'd30, 255);
    ack_en = 1'b1;

    // Randomised reads within and beyond the file
    for (int n = 0; n < 40; n++) begin
      ack_delay = $urandom_range(0, 6);
      begin
        logic [15:0] off;
        off = 16'($urandom_range(0, 40));
        do_read(off, (off >= 16'd24 && off < s_size) ? ack_delay + 1 : 0);
      end
    end
    end_session();

    // Abort: session dropped while waiting, ack 5 cycles after the drop
    start_session(16'h7AE9, 16'h7B00, VZ_TYPE_BASIC, 1'b0);
    do_read(16'd3, 0);
    ack_delay = 7;
    @(negedge clk);
    bus.ioctl_addr = 16'd25;
    bus.ioctl_rd   = 1'b1;
    @(posedge clk); #1;
    bus.ioctl_rd = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.ioctl_upload = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("abort_mem_rd", bus.mem_rd, 1'b1);
      check("abort_busy", busy, 1'b1);
    end
    @(posedge clk); #1;
    check("abort_rd_drop", bus.mem_rd, 1'b0);
    check("abort_busy_drop", busy, 1'b0);
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_wait", bus.ioctl_wait, 1'b0);
    check("abort_din", bus.ioctl_din, last_exp);

    // Asynchronous reset while a request is outstanding
    ack_delay = 3;
    start_session(16'h7AE9, 16'h7B00, VZ_TYPE_BASIC, 1'b0);
    @(negedge clk);
    bus.ioctl_addr = 16'd24;
    bus.ioctl_rd   = 1'b1;
    @(posedge clk); #1;
    bus.ioctl_rd = 1'b0;
    check("pre_rst_state", dbg_state, ST_MREQ);
    #2;
    reset            = 1'b1;
    bus.ioctl_upload = 1'b0;
    #1;
    check("arst_mem_rd", bus.mem_rd, 1'b0);
    check("arst_wait", bus.ioctl_wait, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_size", upload_size, 16'h0);
    check("arst_mem_addr", bus.mem_addr, 16'h0);
    check("arst_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("late_ack_state", dbg_state, ST_IDLE);
    check("late_ack_din", bus.ioctl_din, 8'h00);

`ifdef VZ_UPLOAD_SUM_EN
    ram[16'h4000] = 8'h80;
    ram[16'h4001] = 8'h90;
    ack_delay = 1;
    start_session(16'h4000, 16'h4002, VZ_TYPE_BIN, 1'b0);
    check("sum_clear", upload_sum, 16'h0000);
    do_read(16'd24, 2);
    do_read(16'd25, 2);
    do_read(16'd26, 0);
    check("sum_value", upload_sum, 16'h0110);
    end_session();
    check("sum_frozen", upload_sum, 16'h0110);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
